// File: rtl/layer_4_if.sv
// rtl/layer_4_if.sv - d1/d2 in, e1/ep out bundle for the fourth reduction layer
interface layer_4_if;
  logic        in_valid;
  logic [23:1] d1;
  logic [31:9] d2;
  logic [31:1] e1;
  logic [24:9] ep;
  logic        ep_any;
  logic        out_valid;

  // Producer side: drives the two partial-product rows.
  modport master (
    output in_valid, d1, d2,
    input  e1, ep, ep_any, out_valid
  );

  // Reduction stage side.
  modport slave (
    input  in_valid, d1, d2,
    output e1, ep, ep_any, out_valid
  );
endinterface

// File: rtl/layer_4.sv
// rtl/layer_4.sv - approximate OR-merge of rows d1/d2 into e1 with error vector ep (LAYER_4_ERR_VEC_EN)
module layer_4 (
  input  logic      clk,
  input  logic      rst_n,
  layer_4_if.slave  bus
);

  logic [31:1] e1_d, e1_q;
  logic        out_valid_d, out_valid_q;

  // Sum row: OR over the overlap, straight pass-through outside it; hold when idle.
  always_comb begin
    e1_d = e1_q;
    if (bus.in_valid) begin
      e1_d[8:1]   = bus.d1[8:1];
      e1_d[23:9]  = bus.d1[23:9] | bus.d2[23:9];
      e1_d[31:24] = bus.d2[31:24];
    end
  end

  // Valid is the input valid delayed one edge, updated every cycle.
  always_comb begin
    out_valid_d = bus.in_valid;
  end

  // Pipeline register for the sum row and valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e1_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      e1_q        <= e1_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.e1        = e1_q;
  assign bus.out_valid = out_valid_q;

`ifdef LAYER_4_ERR_VEC_EN
  logic [24:9] ep_d, ep_q;

  // Lost carries of the OR-merge; weight 24 is alignment padding and never set.
  always_comb begin
    ep_d = ep_q;
    if (bus.in_valid) begin
      ep_d[24]   = 1'b0;
      ep_d[23:9] = bus.d1[23:9] & bus.d2[23:9];
    end
  end

  // Pipeline register for the error vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ep_q <= '0;
    end else begin
      ep_q <= ep_d;
    end
  end

  assign bus.ep     = ep_q;
  assign bus.ep_any = |ep_q;
`else
  assign bus.ep     = '0;
  assign bus.ep_any = 1'b0;
`endif

endmodule

// File: tb/tb_layer_4.sv
// tb/tb_layer_4.sv - randomized scoreboard bench for layer_4
module tb_layer_4;

  typedef struct packed {
    logic [30:0] e1;
    logic [15:0] ep;
    logic [63:0] sum;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  layer_4_if bus ();
  layer_4 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks   = 0;
  int failures = 0;

  exp_t        q[$];
  exp_t        mon_x;
  logic [30:0] last_e1;
  logic [15:0] last_ep;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: place each row at its weight, OR gives the sum row, AND gives the lost carries.
  function automatic exp_t model(input logic [23:1] a, input logic [31:9] b);
    exp_t        x;
    logic [63:0] wa, wb;
    wa    = 64'(a) << 1;
    wb    = 64'(b) << 9;
    x.e1  = 31'((wa | wb) >> 1);
`ifdef LAYER_4_ERR_VEC_EN
    x.ep  = 16'((wa & wb) >> 9);
`else
    x.ep  = 16'h0;
`endif
    x.sum = wa + wb;
    return x;
  endfunction

  task automatic drive(input logic v, input logic [23:1] a, input logic [31:9] b, input exp_t x);
    bus.in_valid = v;
    bus.d1       = a;
    bus.d2       = b;
    if (v) q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic v, input logic [23:1] a, input logic [31:9] b);
    drive(v, a, b, model(a, b));
  endtask

  task automatic send_exp(input logic [23:1] a, input logic [31:9] b,
                          input logic [30:0] e, input logic [15:0] p);
    exp_t x;
    x    = model(a, b);
    x.e1 = e;
    x.ep = p;
    drive(1'b1, a, b, x);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_e1"},  64'(bus.e1), 64'h0);
    chk({tag, "_ep"},  64'(bus.ep), 64'h0);
    chk({tag, "_any"}, 64'(bus.ep_any), 64'h0);
    chk({tag, "_ov"},  64'(bus.out_valid), 64'h0);
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    q.delete();
    last_e1 = '0;
    last_ep = '0;
    bus.in_valid = 1'b1;
    bus.d1 = 23'($urandom) | 23'h1;
    bus.d2 = 23'($urandom) | 23'h1;
    #1;
    check_zero({tag, "_imm"});
    repeat (2) @(posedge clk);
    #1;
    check_zero({tag, "_held"});
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop on every valid output, otherwise outputs must hold the last result.
  always @(negedge clk) begin
    if (bus.out_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out actual=out_valid required=no_pending");
      end else begin
        mon_x = q.pop_front();
        chk("e1", 64'(bus.e1), 64'(mon_x.e1));
        chk("ep", 64'(bus.ep), 64'(mon_x.ep));
        chk("ep_any", 64'(bus.ep_any), 64'(|mon_x.ep));
`ifdef LAYER_4_ERR_VEC_EN
        chk("exact", (64'(bus.e1) << 1) + (64'(bus.ep) << 9), mon_x.sum);
`endif
        last_e1 = mon_x.e1;
        last_ep = mon_x.ep;
      end
    end else begin
      chk("hold_e1", 64'(bus.e1), 64'(last_e1));
      chk("hold_ep", 64'(bus.ep), 64'(last_ep));
      chk("hold_any", 64'(bus.ep_any), 64'(|last_ep));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [22:0] pat;
    logic [15:0] ep_pat, ep_ones;
    pat = 23'b00001111000011110000111;
`ifdef LAYER_4_ERR_VEC_EN
    ep_pat  = 16'h0787;
    ep_ones = 16'h7FFF;
`else
    ep_pat  = 16'h0;
    ep_ones = 16'h0;
`endif
    last_e1 = '0;
    last_ep = '0;

    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.d1       = 23'h5A5A5A;
    bus.d2       = 23'h3C3C3C;
    #2;
    check_zero("rst_imm");
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst_held");
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send_exp(pat, pat, 31'h07878787, ep_pat);
    send_exp('1, '1, 31'h7FFFFFFF, ep_ones);
    send_exp('1, '0, 31'h007FFFFF, 16'h0);
    send(1'b0, '0, '0);
    send(1'b0, '0, '0);

    for (int i = 0; i < 3; i++) send(1'b1, 23'($urandom), 23'($urandom));
    for (int i = 0; i < 3; i++) send(1'b0, 23'($urandom), 23'($urandom));

    for (int i = 0; i < 3; i++) send(1'b1, 23'($urandom), 23'($urandom));
    do_reset("rst_mid");

    for (int i = 0; i < 200; i++) begin
      send($urandom_range(0, 3) != 0, 23'($urandom), 23'($urandom));
      if (i == 100) do_reset("rst_rand");
    end

    for (int i = 0; i < 3; i++) send(1'b0, '0, '0);
    chk("drain", 64'(q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
